// File: rtl/bconv_output_collector.sv
// Binarises the PE array's partial-sum stream against a threshold, packs the bits
// LSB-first per output row and queues the words in a small FIFO. Option: BCONV_COLLECTOR_RAW_TAP_EN.
module bconv_output_collector #(
    parameter int PSUM_WIDTH = 5,
    parameter int WORD_WIDTH = 8,
    parameter int OUT_COLS   = 26,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          thresh_load,
    input  logic [PSUM_WIDTH-1:0]         thresh_in,
    input  logic [PSUM_WIDTH-1:0]         psum_in,
    input  logic                          psum_valid,
    output logic [WORD_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
`ifdef BCONV_COLLECTOR_RAW_TAP_EN
    output logic [PSUM_WIDTH-1:0]         raw_psum_out,
    output logic                          raw_psum_valid,
`endif
    output logic                          overflow
);
    localparam int BW   = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int CW   = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [BW-1:0]   BIT_LAST = BW'(WORD_WIDTH - 1);
    localparam logic [CW-1:0]   COL_LAST = CW'(OUT_COLS - 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);

    logic [PSUM_WIDTH-1:0] threshold_q, threshold_d;
    logic [BW-1:0]         bit_idx_q, bit_idx_d;
    logic [CW-1:0]         col_q, col_d;
    logic [WORD_WIDTH-1:0] pack_q, pack_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]       count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [PSUM_WIDTH-1:0] raw_psum_q, raw_psum_d;
    logic                  raw_valid_q, raw_valid_d;
    logic [WORD_WIDTH:0]   mem_q [FIFO_DEPTH];

    logic                  bit_s, last_col_s, word_done_s, pop_s, push_s;
    logic [WORD_WIDTH-1:0] word_s;

    // Binarise, pack, FIFO pointer and counter next-state.
    always_comb begin
        threshold_d = threshold_q;
        bit_idx_d   = bit_idx_q;
        col_d       = col_q;
        pack_d      = pack_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        raw_psum_d  = raw_psum_q;
        raw_valid_d = 1'b0;
        push_s      = 1'b0;

        bit_s       = ($signed(psum_in) >= $signed(threshold_q));
        last_col_s  = (col_q == COL_LAST);
        word_s      = pack_q;
        word_s[bit_idx_q] = bit_s;
        word_done_s = psum_valid && !clear && ((bit_idx_q == BIT_LAST) || last_col_s);
        pop_s       = (count_q != {CNTW{1'b0}}) && out_ready && !clear;

        if (thresh_load) begin
            threshold_d = thresh_in;
        end else begin
            threshold_d = threshold_q;
        end

        if (clear) begin
            bit_idx_d = {BW{1'b0}};
            col_d     = {CW{1'b0}};
            pack_d    = {WORD_WIDTH{1'b0}};
            wr_ptr_d  = {AW{1'b0}};
            rd_ptr_d  = {AW{1'b0}};
            count_d   = {CNTW{1'b0}};
        end else begin
            if (psum_valid) begin
                raw_psum_d  = psum_in;
                raw_valid_d = 1'b1;
                col_d       = last_col_s ? {CW{1'b0}} : col_q + {{(CW-1){1'b0}}, 1'b1};
                if (word_done_s) begin
                    bit_idx_d = {BW{1'b0}};
                    pack_d    = {WORD_WIDTH{1'b0}};
                    // A full FIFO still takes the word if the head leaves this cycle.
                    if ((count_q != CNT_FULL) || pop_s) begin
                        push_s = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else begin
                    bit_idx_d = bit_idx_q + {{(BW-1){1'b0}}, 1'b1};
                    pack_d    = word_s;
                end
            end else begin
                raw_valid_d = 1'b0;
            end

            if (push_s) begin
                wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + {{(CNTW-1){1'b0}}, 1'b1};
                2'b01:   count_d = count_q - {{(CNTW-1){1'b0}}, 1'b1};
                default: count_d = count_q;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            threshold_q <= {PSUM_WIDTH{1'b0}};
            bit_idx_q   <= {BW{1'b0}};
            col_q       <= {CW{1'b0}};
            pack_q      <= {WORD_WIDTH{1'b0}};
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CNTW{1'b0}};
            overflow_q  <= 1'b0;
            raw_psum_q  <= {PSUM_WIDTH{1'b0}};
            raw_valid_q <= 1'b0;
        end else begin
            threshold_q <= threshold_d;
            bit_idx_q   <= bit_idx_d;
            col_q       <= col_d;
            pack_q      <= pack_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            raw_psum_q  <= raw_psum_d;
            raw_valid_q <= raw_valid_d;
        end
    end

    // FIFO storage; each entry is {last, word}.
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            mem_q[wr_ptr_q] <= {last_col_s, word_s};
        end
    end

    assign out_valid  = (count_q != {CNTW{1'b0}});
    assign out_data   = out_valid ? mem_q[rd_ptr_q][WORD_WIDTH-1:0] : {WORD_WIDTH{1'b0}};
    assign out_last   = out_valid ? mem_q[rd_ptr_q][WORD_WIDTH] : 1'b0;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
`ifdef BCONV_COLLECTOR_RAW_TAP_EN
    assign raw_psum_out   = raw_psum_q;
    assign raw_psum_valid = raw_valid_q;
`endif
endmodule

// File: tb/tb_bconv_output_collector.sv
// Self-checking bench for bconv_output_collector: directed scenarios plus random traffic
// compared every cycle against a queue-based row/word model.
module tb_bconv_output_collector;
    localparam int PW = 5;
    localparam int WW = 8;
    localparam int OC = 26;
    localparam int FD = 4;
    localparam int CNW = $clog2(FD) + 1;

    logic           clk = 1'b0;
    logic           rst, clear, thresh_load, psum_valid, out_ready;
    logic [PW-1:0]  thresh_in, psum_in;
    logic [WW-1:0]  out_data;
    logic           out_last, out_valid, overflow;
    logic [CNW-1:0] fifo_count;
`ifdef BCONV_COLLECTOR_RAW_TAP_EN
    logic [PW-1:0]  raw_psum_out;
    logic           raw_psum_valid;
`endif

    always #5 clk = ~clk;

    bconv_output_collector #(.PSUM_WIDTH(PW), .WORD_WIDTH(WW), .OUT_COLS(OC), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .clear(clear), .thresh_load(thresh_load), .thresh_in(thresh_in),
        .psum_in(psum_in), .psum_valid(psum_valid), .out_data(out_data), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .fifo_count(fifo_count),
`ifdef BCONV_COLLECTOR_RAW_TAP_EN
        .raw_psum_out(raw_psum_out), .raw_psum_valid(raw_psum_valid),
`endif
        .overflow(overflow));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: column position within the row, bits of the word in progress,
    // and the queued words as {last, data}.
    int            m_thr;
    int            m_col;
    logic [WW-1:0] m_word;
    logic [WW:0]   m_q[$];
    bit            m_ovf;
    bit            m_raw_v;
    logic [PW-1:0] m_raw;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_thr = 0; m_col = 0; m_word = '0; m_q.delete(); m_ovf = 1'b0;
        m_raw_v = 1'b0; m_raw = '0;
    endtask

    task automatic model_step(input bit clr, input bit vld, input logic [PW-1:0] ps,
                              input bit tl, input logic [PW-1:0] ti, input bit rdy);
        int  p;
        bit  b;
        bit  pop;
        p = $signed(ps);
        pop = (m_q.size() > 0) && rdy;
        m_raw_v = 1'b0;
        if (clr) begin
            m_q.delete(); m_col = 0; m_word = '0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (vld) begin
                b = (p >= m_thr);
                m_word[m_col % WW] = b;
                m_raw_v = 1'b1; m_raw = ps;
                if ((m_col % WW == WW - 1) || (m_col == OC - 1)) begin
                    if (m_q.size() < FD) m_q.push_back({(m_col == OC - 1), m_word});
                    else m_ovf = 1'b1;
                    m_word = '0;
                end
                m_col = (m_col + 1) % OC;
            end
        end
        if (tl) m_thr = $signed(ti);
    endtask

    task automatic check_outputs();
        check_eq("out_valid", out_valid, m_q.size() > 0);
        check_eq("fifo_count", fifo_count, m_q.size());
        check_eq("overflow", overflow, m_ovf);
        if (m_q.size() > 0) begin
            check_eq("out_data", out_data, m_q[0][WW-1:0]);
            check_eq("out_last", out_last, m_q[0][WW]);
        end
`ifdef BCONV_COLLECTOR_RAW_TAP_EN
        check_eq("raw_valid", raw_psum_valid, m_raw_v);
        if (m_raw_v) check_eq("raw_psum", raw_psum_out, m_raw);
`endif
    endtask

    task automatic cycle(input bit clr, input bit vld, input logic [PW-1:0] ps,
                         input bit tl, input logic [PW-1:0] ti, input bit rdy);
        clear = clr; psum_valid = vld; psum_in = ps; thresh_load = tl; thresh_in = ti; out_ready = rdy;
        model_step(clr, vld, ps, tl, ti, rdy);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1; clear = 1'b0; psum_valid = 1'b0; psum_in = '0;
        thresh_load = 1'b0; thresh_in = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_last", out_last, 1'b0);
        check_eq("rst_ovf", overflow, 1'b0);
`ifdef BCONV_COLLECTOR_RAW_TAP_EN
        check_eq("rst_raw_valid", raw_psum_valid, 1'b0);
        check_eq("rst_raw_psum", raw_psum_out, 0);
`endif
    endtask

    initial begin
        do_reset();

        // Alternating +1/-1 row, consumer always ready.
        for (int i = 0; i < OC; i++) cycle(1'b0, 1'b1, (i % 2 == 0) ? 5'sd1 : -5'sd1, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);

        // Threshold equality: -3 >= -3 counts as 1.
        cycle(1'b0, 1'b0, 5'd0, 1'b1, -5'sd3, 1'b0);
        cycle(1'b0, 1'b1, -5'sd3, 1'b0, 5'd0, 1'b0);
        cycle(1'b0, 1'b1, -5'sd5, 1'b0, 5'd0, 1'b0);
        cycle(1'b0, 1'b1, -5'sd2, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 23; i++) cycle(1'b0, 1'b1, -5'sd9, 1'b0, 5'd0, 1'b0);
        check_eq("thr_head", out_data, 8'h05);
        check_eq("thr_count", fifo_count, 4);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);

        // Overflow: 40 psums, nothing drained.
        cycle(1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 5'sd7, 1'b0, 5'd0, 1'b0);
        check_eq("ovf_flag", overflow, 1'b1);
        check_eq("ovf_count", fifo_count, 4);
        check_eq("ovf_head", out_data, 8'hFF);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        check_eq("ovf_drained", fifo_count, 0);

        // Full FIFO with a pop in the same cycle the next word completes.
        do_reset();
        for (int i = 0; i < OC + 7; i++) cycle(1'b0, 1'b1, 5'sd7, 1'b0, 5'd0, 1'b0);
        check_eq("full_count", fifo_count, 4);
        cycle(1'b0, 1'b1, 5'sd7, 1'b0, 5'd0, 1'b1);
        check_eq("fullpop_ovf", overflow, 1'b0);
        check_eq("fullpop_count", fifo_count, 4);

        // Clear mid-row discards the partial word; clear with psum drops the psum.
        cycle(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 5'sd1, 1'b0, 5'd0, 1'b1);
        cycle(1'b1, 1'b1, 5'sd1, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < OC; i++) cycle(1'b0, 1'b1, 5'sd1, 1'b0, 5'd0, 1'b0);
        check_eq("clr_head", out_data, 8'hFF);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);

        // Raw tap / negative psum.
        cycle(1'b0, 1'b1, -5'sd7, 1'b0, 5'd0, 1'b1);
        cycle(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 5'($urandom),
                  ($urandom_range(0, 19) == 0), 5'($urandom), ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bconv_output_collector.md
# bconv_output_collector

Receive-side block for the XNOR convolution PE array. It accepts the array's signed partial-sum stream (`partial_sum_out`/`valid` pair). Each partial sum is binarised against a programmable threshold (sign activation with folded batch-norm offset), and the bits are packed LSB-first into words along one output-feature-map row. Packed words are buffered in a small FIFO with a valid/ready output handshake toward the feature-map write-back logic.

## Interface
Parameters:
- `PSUM_WIDTH`, 5 — signed partial-sum width; matches the array output.
- `WORD_WIDTH`, 8 — packed output word width, in bits.
- `OUT_COLS`, 26 — output columns per row (28-wide input, 3x3 kernel). Must be at least 1.
- `FIFO_DEPTH`, 4 — output FIFO entries. Must be a power of 2 and at least 2.

Ports:
- `clk` in 1 — the single clock; all state changes on its rising edge.
- `rst` in 1 — synchronous reset, active-high.
- `clear` in 1 — synchronous frame restart. Empties the FIFO and zeroes the counters and the pack register. Does not affect the threshold or `overflow`.
- `thresh_load` in 1 — loads `thresh_in` into the threshold register.
- `thresh_in` in PSUM_WIDTH — signed threshold value.
- `psum_in` in PSUM_WIDTH — signed partial sum; driven by the array's `partial_sum_out`.
- `psum_valid` in 1 — qualifies `psum_in`; driven by the array's `valid`. There is no back-pressure on this input.
- `out_data` out WORD_WIDTH — packed word at the FIFO head.
- `out_last` out 1 — the head word is the final word of a row.
- `out_valid` out 1 — the FIFO is not empty.
- `out_ready` in 1 — consumer accepts the head word.
- `fifo_count` out $clog2(FIFO_DEPTH)+1 — current FIFO occupancy.
- `overflow` out 1 — sticky; set when a completed word is dropped.

## Operation
- **Binarise:** bit = (psum_in >= threshold), using a signed comparison.
  - Example: psum −9 with threshold 0 gives 0.
- **Counters and pack register:**
  - `bit_idx` ranges 0..WORD_WIDTH−1.
  - `col` ranges 0..OUT_COLS−1.
  - `pack` is a WORD_WIDTH-bit register.
- **Each accepted psum:**
  - The new bit is written to `pack[bit_idx]`.
  - The word completes when `bit_idx == WORD_WIDTH−1` or `col == OUT_COLS−1`.
- **On word completion:**
  - The word (`pack` plus the new bit, with unused upper bits zero) is pushed together with last = (`col == OUT_COLS−1`).
  - `bit_idx` and `pack` are zeroed.
- **Counter advance:** `col` increments and wraps to 0 after OUT_COLS−1. Otherwise `bit_idx` increments.
- **Words per row:** ceil(OUT_COLS/WORD_WIDTH). Rows never share a word.
- **FIFO push/pop:**
  - Pop occurs when `out_valid && out_ready`.
  - A push when the FIFO is full and there is no pop in the same cycle drops the word and sets `overflow`. The counters still advance.
  - A push when the FIFO is full with a simultaneous pop is accepted, with no overflow.
  - A pop when the FIFO is empty is ignored.
- **Reset values** after `rst`:
  - `threshold` = 0, counters = 0, `pack` = 0.
  - FIFO empty: `out_valid` = 0, `fifo_count` = 0, `out_data` = 0, `out_last` = 0.
  - `overflow` = 0.
- **Priority:** `rst` > `clear` > `psum_valid`.
  - A psum presented in the same cycle as `clear` is discarded.
  - `thresh_load` is honoured in the same cycle as `clear`.
  - `clear` mid-row discards any partial word.
- **Threshold update:** a `thresh_load` in the same cycle as `psum_valid` updates the threshold at that edge. That psum uses the old threshold.

## Timing
- **Acceptance:** a psum is accepted at edge N when `psum_valid` = 1 at that edge.
- **Output latency:** a word completed at edge N is in the FIFO after edge N.
  - If the FIFO was empty, `out_valid` = 1 in cycle N+1. This is 1-cycle latency.
- **Throughput:** one psum per cycle sustained. One word pop per cycle.
- **Output stability:** `out_data` and `out_last` are stable while `out_valid` = 1 and `out_ready` = 0.
- **`fifo_count`:** reflects the state after each edge; +1 on push, −1 on pop, unchanged on both.
- **`overflow`:** rises in the cycle after the dropped push. Cleared only by `rst`.

## Configuration
- Macro: `BCONV_COLLECTOR_RAW_TAP_EN`.
- **Defined:** adds two outputs:
  - `raw_psum_out` (PSUM_WIDTH, signed) — registered copy of each accepted `psum_in`.
  - `raw_psum_valid` (1) — high for one cycle, in the cycle after acceptance.
  - Both are 0 after `rst`. A psum discarded by `clear` produces no pulse.
- **Undefined:** neither port exists, and the binarised path behaves identically.

## Test plan
- **Alternating row:** threshold 0, `out_ready` = 1, 26 psums alternating +1, −1 → words 0x55, 0x55, 0x55, 0x01; only the 0x01 word has `out_last` = 1. Each word is valid 1 cycle after its final psum.
- **Threshold equality:** load threshold −3, then psums −3, −5, −2, then 23 × −9 → first word 0x05; remaining words 0x00 with `out_last` on the 4th word.
- **Overflow:** `out_ready` = 0, 40 psums of +7 → FIFO holds 4 words (0xFF, 0xFF, 0xFF, 0x03 with last = 1, then 0xFF); the 5th completed word is dropped and `overflow` = 1. Drained order is preserved and `fifo_count` decrements 4 → 0.
- **Full with simultaneous pop:** FIFO full, `out_ready` = 1 in the same cycle a word completes → word accepted, `overflow` stays 0, `fifo_count` stays 4.
- **Clear mid-row:** 5 psums of +1, then `clear`, then 26 psums of +1 → words 0xFF, 0xFF, 0xFF, 0x03 (last); no residue from the first 5 psums.
- **Raw tap (macro defined):** psum −7 accepted at edge N → `raw_psum_out` = −7 and `raw_psum_valid` = 1 in cycle N+1 only.
